// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares the single RAM port of the pipelined MIPS core between instruction
// fetch (icache side) and the data path (dcache side). Grants are made one at
// a time by a three-state FSM (IDLE, DGRANT, IGRANT). Data requests normally
// win arbitration; a starvation counter forces one instruction grant after
// STARVE_MAX data grants were issued while an instruction fetch was waiting.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      word width
//   STARVE_MAX  data grants tolerated with iREN pending (1..15)
//
// Ports
//   CLK       in   system clock, rising edge
//   nRST      in   asynchronous active-low reset
//   iREN      in   instruction read request
//   iaddr     in   instruction address
//   iwait     out  instruction stall, low only in the completing cycle
//   iload     out  instruction word, valid when iwait=0 and iREN=1
//   dREN      in   data read request
//   dWEN      in   data write request
//   daddr     in   data address
//   dstore    in   data write word
//   dwait     out  data stall, low only in the completing cycle
//   dload     out  data read word, valid when dwait=0 and dREN=1
//   ramREN    out  RAM read enable
//   ramWEN    out  RAM write enable
//   ramaddr   out  RAM address
//   ramstore  out  RAM write data
//   ramload   in   RAM read data
//   ramstate  in   RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DGRANT = 2'd1,
        ST_IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    // The counter is four bits wide, which bounds STARVE_MAX at 15.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] v);
        if (v >= STARVE_LIM) begin
            return STARVE_LIM;
        end
        return v + 4'd1;
    endfunction

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_starve;
    logic [3:0] w_next_starve;
    // Remembers whether instruction fetch was already waiting when the
    // current data grant was made; only such grants count toward starvation.
    logic       r_iren_at_grant;
    logic       w_next_iren_at_grant;

    logic       w_dreq;
    logic       w_access;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == RAM_ACCESS);

    // ---- state register ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state         <= ST_IDLE;
            r_starve        <= 4'd0;
            r_iren_at_grant <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_starve        <= w_next_starve;
            r_iren_at_grant <= w_next_iren_at_grant;
        end
    end

    // ---- next state and outputs ----
    // Everything below is combinational on r_state, so an asynchronous reset
    // forces IDLE and the RAM enables drop without waiting for a clock edge.
    always_comb begin
        w_next_state         = r_state;
        w_next_starve        = r_starve;
        w_next_iren_at_grant = r_iren_at_grant;
        ramREN               = 1'b0;
        ramWEN               = 1'b0;
        ramaddr              = '0;
        ramstore             = '0;
        iload                = '0;
        dload                = '0;
        // A requester stalls unless it is the one completing this cycle.
        iwait                = iREN;
        dwait                = w_dreq;

        case (r_state)
            ST_IDLE: begin
                // Registered arbitration: the RAM port stays idle for one
                // bubble cycle while the winner is chosen.
                if (w_dreq && (r_starve < STARVE_LIM)) begin
                    w_next_state         = ST_DGRANT;
                    w_next_iren_at_grant = iREN;
                end else if (iREN) begin
                    w_next_state = ST_IGRANT;
                end else if (w_dreq) begin
                    // Counter saturated but nobody is fetching: data may go.
                    w_next_state         = ST_DGRANT;
                    w_next_iren_at_grant = 1'b0;
                end
            end

            ST_DGRANT: begin
                // Write wins when both read and write are raised.
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!w_dreq) begin
                    // Aborted before completion: no handshake, count kept.
                    w_next_state = ST_IDLE;
                end else if (w_access) begin
                    dwait         = 1'b0;
                    dload         = ramload;
                    w_next_state  = ST_IDLE;
                    w_next_starve = r_iren_at_grant ? starve_inc(r_starve) : 4'd0;
                end
            end

            ST_IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    w_next_state = ST_IDLE;
                end else if (w_access) begin
                    iwait         = 1'b0;
                    iload         = ramload;
                    w_next_state  = ST_IDLE;
                    w_next_starve = 4'd0;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    memory_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = RS_FREE;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        next_cycle();
        nRST = 1'b1;
    endtask

    // Table of one-cycle vectors applied back to back after a reset.
    typedef struct {
        logic        ir, dr, dw;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_ren, e_wen, e_iwait, e_dwait;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
    } vec_t;

    vec_t vecs[9];

    // Behavioural reference: who owns the RAM port, the starvation tally and
    // whether fetch was waiting when the current data grant was handed out.
    int m_owner;   // 0 none, 1 data, 2 instruction
    int m_starve;
    bit m_iat;

    initial begin
        byte grants[$];
        string exp_seq;
        byte exp_c;
        int cyc;
        logic dreq, rst_now;
        logic e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        bit d_done, i_done;

        //                ir dr dw rs         rl            ren wen iw dw addr        store         iload         dload
        vecs[0] = '{1'b1,1'b0,1'b0,RS_BUSY,  32'h0,        0,0,1,0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1,1'b0,1'b0,RS_BUSY,  32'h0,        1,0,1,0, 32'h40,  32'h0,        32'h0,        32'h0};
        vecs[2] = '{1'b1,1'b0,1'b0,RS_BUSY,  32'h0,        1,0,1,0, 32'h40,  32'h0,        32'h0,        32'h0};
        vecs[3] = '{1'b1,1'b0,1'b0,RS_ACCESS,32'h8C220004, 1,0,0,0, 32'h40,  32'h0,        32'h8C220004, 32'h0};
        vecs[4] = '{1'b0,1'b0,1'b0,RS_FREE,  32'h0,        0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[5] = '{1'b0,1'b1,1'b1,RS_FREE,  32'h0,        0,0,0,1, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[6] = '{1'b0,1'b1,1'b1,RS_FREE,  32'h0,        0,1,0,1, 32'h100, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[7] = '{1'b0,1'b1,1'b1,RS_ACCESS,32'h12345678, 0,1,0,0, 32'h100, 32'hDEADBEEF, 32'h0,        32'h12345678};
        vecs[8] = '{1'b0,1'b0,1'b0,RS_FREE,  32'h0,        0,0,0,0, 32'h0,   32'h0,        32'h0,        32'h0};

        // ---------------- reset with both requesters pending ----------------
        clear_inputs();
        nRST = 1'b0;
        iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h300;
        #1;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        next_cycle();
        chk("rst_hold_ramREN", ramREN, 0);
        nRST = 1'b1;
        next_cycle();
        chk("rst_rel_dgrant_ramREN", ramREN, 1);
        chk("rst_rel_dgrant_addr", ramaddr, 32'h300);
        chk("rst_rel_iwait", iwait, 1);

        // ---------------- table vectors ----------------
        do_reset();
        iaddr = 32'h40; daddr = 32'h100; dstore = 32'hDEADBEEF;
        for (int i = 0; i < 9; i++) begin
            iREN = vecs[i].ir; dREN = vecs[i].dr; dWEN = vecs[i].dw;
            ramstate = vecs[i].rs; ramload = vecs[i].rl;
            #1;
            chk($sformatf("tbl%0d_ramREN", i), ramREN, vecs[i].e_ren);
            chk($sformatf("tbl%0d_ramWEN", i), ramWEN, vecs[i].e_wen);
            chk($sformatf("tbl%0d_iwait", i), iwait, vecs[i].e_iwait);
            chk($sformatf("tbl%0d_dwait", i), dwait, vecs[i].e_dwait);
            chk($sformatf("tbl%0d_ramaddr", i), ramaddr, vecs[i].e_addr);
            chk($sformatf("tbl%0d_ramstore", i), ramstore, vecs[i].e_store);
            chk($sformatf("tbl%0d_iload", i), iload, vecs[i].e_iload);
            chk($sformatf("tbl%0d_dload", i), dload, vecs[i].e_dload);
            next_cycle();
        end

        // ---------------- starvation: grant order ----------------
        do_reset();
        iREN = 1; iaddr = 32'h40; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramstate = RS_ACCESS; ramload = 32'h0;
        cyc = 0;
        while (grants.size() < 10 && cyc < 100) begin
            #1;
            if (!dwait && ramWEN) begin
                grants.push_back("D");
                chk("starve_dstore", ramstore, 32'hDEADBEEF);
            end
            if (!iwait && ramREN && !ramWEN) grants.push_back("I");
            cyc++;
            next_cycle();
        end
        exp_seq = "DDDDIDDDDI";
        if (grants.size() < 10) begin
            n_checks++;
            n_fail++;
            $display("FAIL starve_timeout: got %0d grants required 10", grants.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                exp_c = exp_seq[i];
                chk($sformatf("starve_grant%0d", i), grants[i], exp_c);
            end
        end

        // ---------------- data abort, then pending fetch ----------------
        do_reset();
        iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h200; ramstate = RS_BUSY;
        #1;
        chk("abort_idle_dwait", dwait, 1);
        next_cycle();
        chk("abort_dgrant_ramREN", ramREN, 1);
        chk("abort_dgrant_addr", ramaddr, 32'h200);
        chk("abort_dgrant_dwait", dwait, 1);
        next_cycle();
        chk("abort_busy_dwait", dwait, 1);
        dREN = 0;
        #1;
        chk("abort_drop_ramREN", ramREN, 0);
        chk("abort_drop_dload", dload, 0);
        next_cycle();
        chk("abort_idle_ramREN", ramREN, 0);
        chk("abort_idle_iwait", iwait, 1);
        next_cycle();
        chk("abort_igrant_ramREN", ramREN, 1);
        chk("abort_igrant_addr", ramaddr, 32'h40);

        // ---------------- error retries during fetch ----------------
        ramstate = RS_ERROR;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("err%0d_iwait", k), iwait, 1);
            chk($sformatf("err%0d_ramREN", k), ramREN, 1);
            chk($sformatf("err%0d_iload", k), iload, 0);
            next_cycle();
        end
        ramstate = RS_ACCESS; ramload = 32'hCAFEF00D;
        #1;
        chk("err_done_iwait", iwait, 0);
        chk("err_done_iload", iload, 32'hCAFEF00D);
        next_cycle();
        ramstate = RS_BUSY;
        #1;
        chk("err_after_idle_ramREN", ramREN, 0);
        next_cycle();
        chk("midrst_igrant_ramREN", ramREN, 1);

        // ---------------- asynchronous reset mid-grant ----------------
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_ramREN", ramREN, 0);
        chk("midrst_ramaddr", ramaddr, 0);
        chk("midrst_iwait", iwait, 1);
        #1;
        nRST = 1'b1;
        next_cycle();

        // ---------------- randomized run against the reference ----------------
        do_reset();
        m_owner = 0; m_starve = 0; m_iat = 0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) dREN = ~dREN;
            if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            case ($urandom_range(0, 9))
                0, 1:    ramstate = RS_FREE;
                2, 3:    ramstate = RS_BUSY;
                4:       ramstate = RS_ERROR;
                default: ramstate = RS_ACCESS;
            endcase
            rst_now = ($urandom_range(0, 199) == 0);
            if (rst_now) nRST = 1'b0;
            #1;
            if (rst_now) begin
                m_owner = 0; m_starve = 0; m_iat = 0;
            end
            dreq   = dREN | dWEN;
            d_done = (m_owner == 1) && dreq && (ramstate == RS_ACCESS);
            i_done = (m_owner == 2) && iREN && (ramstate == RS_ACCESS);
            e_ren   = (m_owner == 1) ? (dREN && !dWEN) : (m_owner == 2) ? iREN : 1'b0;
            e_wen   = (m_owner == 1) ? dWEN : 1'b0;
            e_addr  = (m_owner == 1) ? daddr : (m_owner == 2) ? iaddr : 32'h0;
            e_store = (m_owner == 1) ? dstore : 32'h0;
            e_iw    = iREN && !i_done;
            e_dw    = dreq && !d_done;
            e_il    = i_done ? ramload : 32'h0;
            e_dl    = d_done ? ramload : 32'h0;
            chk("rnd_ramREN", ramREN, e_ren);
            chk("rnd_ramWEN", ramWEN, e_wen);
            chk("rnd_ramaddr", ramaddr, e_addr);
            chk("rnd_ramstore", ramstore, e_store);
            chk("rnd_iwait", iwait, e_iw);
            chk("rnd_dwait", dwait, e_dw);
            chk("rnd_iload", iload, e_il);
            chk("rnd_dload", dload, e_dl);
            if (!rst_now) begin
                if (m_owner == 0) begin
                    if (dreq && m_starve < STARVE_MAX) begin
                        m_owner = 1; m_iat = iREN;
                    end else if (iREN) begin
                        m_owner = 2;
                    end else if (dreq) begin
                        m_owner = 1; m_iat = 0;
                    end
                end else if (m_owner == 1) begin
                    if (!dreq) m_owner = 0;
                    else if (d_done) begin
                        m_owner = 0;
                        m_starve = m_iat ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
                    end
                end else begin
                    if (!iREN) m_owner = 0;
                    else if (i_done) begin
                        m_owner = 0;
                        m_starve = 0;
                    end
                end
            end
            next_cycle();
            nRST = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single RAM port between the instruction fetch path (icache side) and the data path (dcache side) of the pipelined MIPS core.
- Serialises requests with a grant FSM. Data requests get priority; a starvation counter guarantees forward progress for instruction fetch.
- Drives the iwait/dwait stalls that feed the pipeline hazard/stall logic.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- STARVE_MAX, 4, consecutive data grants made while iREN is pending before instruction fetch is forced to win one arbitration (range 1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  instruction stall; low for exactly the completing cycle.
- iload  out  DATA_W  instruction word; valid when iwait=0 and iREN=1.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dwait  out  1  data stall; low for exactly the completing cycle.
- dload  out  DATA_W  read data; valid when dwait=0 and dREN=1.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset (async, nRST=0):
  - State IDLE, starve count 0.
  - ramREN=ramWEN=0; ramaddr, ramstore = 0.
  - iwait=dwait=1 whenever the corresponding request is asserted, else 0.
  - iload, dload = 0.
- FSM states: IDLE, DGRANT, IGRANT.
- IDLE arbitration, registered, one-cycle bubble; RAM outputs idle during IDLE:
  - If (dREN|dWEN) and count<STARVE_MAX → DGRANT.
  - Else if iREN → IGRANT.
  - Else if (dREN|dWEN) → DGRANT. This covers count==STARVE_MAX with iREN low.
  - Else stay IDLE.
- DGRANT:
  - Drives ramaddr=daddr, ramWEN=dWEN, ramREN=dREN&~dWEN, ramstore=dstore. dWEN wins if both dREN and dWEN are set.
  - On ramstate==ACCESS: dwait=0 that cycle, dload=ramload (combinational), next state IDLE.
  - Starve count: +1 if iREN was high at grant time (saturating at STARVE_MAX), else cleared.
- IGRANT:
  - Drives ramaddr=iaddr, ramREN=1, ramWEN=0.
  - On ACCESS: iwait=0, iload=ramload, next state IDLE, starve count cleared.
- While granted with ramstate FREE, BUSY or ERROR: hold state and outputs, wait stays 1. ERROR is retried indefinitely.
- Abort: a granted requester dropping its request (dREN=dWEN=0 or iREN=0) before ACCESS → RAM enables drop combinationally, next state IDLE, no completion, count unchanged.
- Non-granted requester always sees wait=1 if requesting, and its load=0.
- Request changing address mid-grant: RAM address follows combinationally. The requester must hold stable; the arbiter does not latch addresses.
- Minimum completion latency: 2 cycles from request in IDLE (1 arbitration + 1 ACCESS cycle). Back-to-back grants always pass through IDLE.
- Reset mid-grant: immediate return to IDLE, RAM enables drop asynchronously.

Test Plan:
- Reset with iREN=1, dREN=1 → ramREN=0, iwait=dwait=1, state IDLE; release → DGRANT on first edge.
- iREN only, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C220004 → ramaddr=0x40, iwait low only in the ACCESS cycle, iload=0x8C220004, total 4 cycles.
- iREN and dWEN both held, daddr=0x100, dstore=0xDEADBEEF, ACCESS every grant, STARVE_MAX=4 → grant sequence D,D,D,D,I,D,D,D,D,I; ramWEN=1 and ramstore=0xDEADBEEF on data grants.
- dREN=dWEN=1 → ramWEN=1, ramREN=0.
- dREN drops while in DGRANT with ramstate BUSY → ramREN=0 that cycle, IDLE next cycle, dwait never low, pending iREN granted after.
- ramstate=ERROR for 3 cycles then ACCESS during IGRANT → iwait held 1 through the errors, completes on ACCESS. nRST pulsed mid-IGRANT → ramREN drops without waiting for a clock edge.
